// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: one operand bit per cycle, N cycles per
// conversion, with a sticky flag for operands that do not fit in D decimal digits.
module binary_to_bcd_converter #(
  parameter int unsigned N = 13,
  parameter int unsigned D = 4
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           start_i,
  input  logic [N-1:0]   binary_i,
  output logic           ready_o,
  output logic           done_o,
  output logic [4*D-1:0] bcd_o,
  output logic           overflow_o
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOp   = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q;
  logic [N-1:0]    shift_q, shift_d;
  logic [4*D-1:0]  acc_q, acc_d, acc_adj;
  logic            ovf_q, ovf_d, carry;
  logic [CntW-1:0] cnt_q;
  logic [4*D-1:0]  bcd_q;
  logic            overflow_q;

  // Add-3 on every digit >= 5, then shift {acc, shift} left; the bit leaving the top digit
  // represents a lost multiple of 10^D.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(D); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    {carry, acc_d, shift_d} = {acc_adj, shift_q, 1'b0};
    ovf_d = ovf_q | carry;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            shift_q <= binary_i;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CntW'(N - 1);
            state_q <= StOp;
          end
        end
        StOp: begin
          shift_q <= shift_d;
          acc_q   <= acc_d;
          ovf_q   <= ovf_d;
          if (cnt_q == '0) begin
            bcd_q      <= acc_d;
            overflow_q <= ovf_d;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o    = (state_q == StIdle);
  assign done_o     = (state_q == StDone);
  assign bcd_o      = bcd_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Bench for binary_to_bcd_converter: a D=4 and a D=3 instance checked every cycle against a
// transaction-level model, plus directed conversions with literal expected results.
module tb_binary_to_bcd_converter;

  localparam int NW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st [2];
  logic [NW-1:0] bin_v [2];
  logic          ready0, ready1, done0, done1, ovf0, ovf1;
  logic [15:0]   bcd0;
  logic [11:0]   bcd1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  binary_to_bcd_converter #(.N(NW), .D(4)) u_dut4 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(st[0]), .binary_i(bin_v[0]),
    .ready_o(ready0), .done_o(done0), .bcd_o(bcd0), .overflow_o(ovf0)
  );

  binary_to_bcd_converter #(.N(NW), .D(3)) u_dut3 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(st[1]), .binary_i(bin_v[1]),
    .ready_o(ready1), .done_o(done1), .bcd_o(bcd1), .overflow_o(ovf1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p *= 10;
    return p;
  endfunction

  function automatic int to_bcd(input int v, input int d);
    int r = 0;
    int x = v % pow10(d);
    for (int k = 0; k < d; k++) begin
      r |= (x % 10) << (4 * k);
      x /= 10;
    end
    return r;
  endfunction

  // Model: phase 0 = idle, 1..NW = working, NW+1 = done pulse.
  int phase [2];
  int opnd [2];
  int exp_bcd [2];
  int exp_ovf [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        phase[i] = 0; opnd[i] = 0; exp_bcd[i] = 0; exp_ovf[i] = 0;
      end else if (phase[i] == 0) begin
        if (st[i]) begin
          phase[i] = 1;
          opnd[i]  = int'(bin_v[i]);
        end
      end else if (phase[i] == NW) begin
        phase[i]   = NW + 1;
        exp_bcd[i] = to_bcd(opnd[i], (i == 0) ? 4 : 3);
        exp_ovf[i] = (opnd[i] >= pow10((i == 0) ? 4 : 3)) ? 1 : 0;
      end else if (phase[i] == NW + 1) begin
        phase[i] = 0;
      end else begin
        phase[i]++;
      end
    end
  end

  always @(negedge clk) begin
    check("ready4", int'(ready0), (phase[0] == 0) ? 1 : 0);
    check("done4",  int'(done0),  (phase[0] == NW + 1) ? 1 : 0);
    check("bcd4",   int'(bcd0),   exp_bcd[0]);
    check("ovf4",   int'(ovf0),   exp_ovf[0]);
    check("ready3", int'(ready1), (phase[1] == 0) ? 1 : 0);
    check("done3",  int'(done1),  (phase[1] == NW + 1) ? 1 : 0);
    check("bcd3",   int'(bcd1),   exp_bcd[1]);
    check("ovf3",   int'(ovf1),   exp_ovf[1]);
  end

  function automatic logic done_of(input int i);
    return (i == 0) ? done0 : done1;
  endfunction

  function automatic int bcd_of(input int i);
    return (i == 0) ? int'(bcd0) : int'(bcd1);
  endfunction

  function automatic int ovf_of(input int i);
    return (i == 0) ? int'(ovf0) : int'(ovf1);
  endfunction

  // Called just after the accepting edge; waits for done and checks latency and result.
  task automatic wait_result(input int i, input int eb, input int eo, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_of(i) && n < 40);
    check({name, " latency"}, n, NW + 1);
    check({name, " bcd"}, bcd_of(i), eb);
    check({name, " ovf"}, ovf_of(i), eo);
  endtask

  task automatic run(input int i, input int v, input int eb, input int eo, input string name);
    @(posedge clk); #1;
    st[i] = 1'b1; bin_v[i] = NW'(v);
    @(posedge clk); #1;
    st[i] = 1'b0; bin_v[i] = ~NW'(v);
    wait_result(i, eb, eo, name);
  endtask

  initial begin
    int pulses, got_bcd, n;
    int t [3];
    st[0] = 1'b0; st[1] = 1'b0; bin_v[0] = '0; bin_v[1] = '0;

    repeat (2) @(negedge clk);
    check("reset ready", int'(ready0), 1);
    check("reset done", int'(done0), 0);
    check("reset bcd", int'(bcd0), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run(0, 0,    'h0000, 0, "zero");
    run(0, 8191, 'h8191, 0, "max");
    run(0, 1234, 'h1234, 0, "1234");
    run(1, 1234, 'h234,  1, "d3 1234");
    run(1, 999,  'h999,  0, "d3 999");

    // Start pulse during OP with a different operand must be ignored.
    @(posedge clk); #1 st[0] = 1'b1; bin_v[0] = NW'(4095);
    @(posedge clk); #1 st[0] = 1'b0; bin_v[0] = '0;
    repeat (3) @(posedge clk);
    #1 st[0] = 1'b1; bin_v[0] = NW'(7);
    @(posedge clk); #1 st[0] = 1'b0;
    pulses = 0; got_bcd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done0) begin
        pulses++;
        got_bcd = int'(bcd0);
      end
    end
    check("ignore start pulses", pulses, 1);
    check("ignore start bcd", got_bcd, 'h4095);

    // Reset mid-conversion.
    @(posedge clk); #1 st[0] = 1'b1; bin_v[0] = NW'(3000);
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort ready", int'(ready0), 1);
    check("abort bcd", int'(bcd0), 0);
    check("abort done", int'(done0), 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    check("abort no done", pulses, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; st[0] = 1'b1; bin_v[0] = NW'(42);
    @(posedge clk); #1 st[0] = 1'b0;
    check("accept first edge", int'(ready0), 0);
    wait_result(0, 'h0042, 0, "after reset");

    // Back-to-back with start held high.
    @(posedge clk); #1 st[0] = 1'b1; bin_v[0] = NW'(1);
    for (int j = 0; j < 3; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done0 && n < 40);
      check("b2b done seen", int'(done0), 1);
      t[j] = cyc;
      check("b2b bcd", int'(bcd0), (j == 0) ? 'h0001 : (j == 1) ? 'h0010 : 'h0100);
      bin_v[0] = (j == 0) ? NW'(10) : NW'(100);
      if (j == 2) st[0] = 1'b0;
    end
    check("b2b spacing 1", t[1] - t[0], NW + 2);
    check("b2b spacing 2", t[2] - t[1], NW + 2);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
